// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler_if
//  Description : Handshake/status bundle between the event sources, the
//                UART transmitter and the uart_tx_scheduler block.
//                slave  = the scheduler itself
//                master = the surrounding logic (requesters + transmitter)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_scheduler_if;
    logic [3:0] req;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic [1:0] grant_id;
    logic [3:0] pending;
    logic [7:0] drop_cnt;
    logic       timeout_err;

    modport slave (
        input  req, tx_busy, tx_done,
        output tx_start, tx_data, busy, grant_id, pending, drop_cnt, timeout_err
    );

    modport master (
        output req, tx_busy, tx_done,
        input  tx_start, tx_data, busy, grant_id, pending, drop_cnt, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmitter among four event requesters.
//                Rising req edges are latched as pending, a round-robin
//                arbiter picks one, and the granted event is sent as a framed
//                byte message through the transmitter start/done handshake.
//                Optional macro UART_TX_CRLF_EN: frames become CODE, CR, LF.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter logic [7:0]  CODE0   = 8'h53,
    parameter logic [7:0]  CODE1   = 8'h42,
    parameter logic [7:0]  CODE2   = 8'h4F,
    parameter logic [7:0]  CODE3   = 8'h52,
    parameter int unsigned TIMEOUT = 2_000_000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    uart_tx_scheduler_if.slave sched
);

    localparam int unsigned c_TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT - 1);

`ifdef UART_TX_CRLF_EN
    localparam int unsigned c_IDX_W = 2;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = 2'd2;
`else
    localparam int unsigned c_IDX_W = 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = 1'b0;
`endif

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_LOAD  = 2'd2;
    localparam logic [1:0] c_WAIT  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_req_q;
    logic [3:0]         r_pending;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_grant;
    logic [c_IDX_W-1:0] r_byte_idx;
    logic [c_TMR_W-1:0] r_timer;
    logic [7:0]         r_tx_data;
    logic [7:0]         r_drop_cnt;
    logic               r_timeout_err;

    logic [3:0]         w_rise;
    logic [3:0]         w_clear;
    logic [3:0]         w_drop;
    logic [2:0]         w_drop_n;
    logic [8:0]         w_drop_sum;
    logic [1:0]         w_rr_grant;
    logic [1:0]         w_idx;
    logic               w_found;
    logic               w_tx_start;
    logic               w_load;
    logic               w_adv;
    logic               w_timeout;
    logic [1:0]         w_sel_id;
    logic [7:0]         w_code;
    logic [7:0]         w_data_nxt;
`ifdef UART_TX_CRLF_EN
    logic [c_IDX_W-1:0] w_sel_idx;
`endif

    // Edge detection and drop accounting; a grant clearing a bit in the same
    // cycle as a new edge keeps the bit set and is not a drop.
    always_comb begin
        w_rise     = sched.req & ~r_req_q;
        w_drop     = w_rise & r_pending & ~w_clear;
        w_drop_n   = {2'b00, w_drop[0]} + {2'b00, w_drop[1]}
                   + {2'b00, w_drop[2]} + {2'b00, w_drop[3]};
        w_drop_sum = {1'b0, r_drop_cnt} + {6'b000000, w_drop_n};
    end

    // Round-robin search starting at r_rr_ptr, wrapping mod 4.
    always_comb begin
        w_rr_grant = r_rr_ptr;
        w_found    = 1'b0;
        w_idx      = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && r_pending[w_idx]) begin
                w_found    = 1'b1;
                w_rr_grant = w_idx;
            end
        end
    end

    // Next byte to present: first byte at GRANT, following bytes on advance.
    always_comb begin
        w_sel_id = (r_state == c_GRANT) ? w_rr_grant : r_grant;
        w_code   = CODE0;
        case (w_sel_id)
            2'd0:    w_code = CODE0;
            2'd1:    w_code = CODE1;
            2'd2:    w_code = CODE2;
            default: w_code = CODE3;
        endcase
`ifdef UART_TX_CRLF_EN
        w_sel_idx = (r_state == c_GRANT) ? '0 : r_byte_idx + 1'b1;
        case (w_sel_idx)
            2'd0:    w_data_nxt = w_code;
            2'd1:    w_data_nxt = 8'h0D;
            default: w_data_nxt = 8'h0A;
        endcase
`else
        w_data_nxt = w_code;
`endif
    end

    // FSM next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_start  = 1'b0;
        w_clear     = 4'b0000;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                // A fresh edge lands in pending at the same edge we enter GRANT.
                if ((r_pending | w_rise) != 4'b0000) begin
                    w_state_nxt = c_GRANT;
                end
            end
            c_GRANT: begin
                w_clear[w_rr_grant] = 1'b1;
                w_load              = 1'b1;
                w_state_nxt         = c_LOAD;
            end
            c_LOAD: begin
                if (!sched.tx_busy) begin
                    w_tx_start  = 1'b1;
                    w_state_nxt = c_WAIT;
                end else if (r_timer == c_TMR_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                if (sched.tx_done) begin
                    if (r_byte_idx == c_LAST_IDX) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_adv       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = c_LOAD;
                    end
                end else if (r_timer == c_TMR_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    // Edge-detect history tracks req even in reset so a req held through
    // reset is not seen as a new event afterwards.
    always_ff @(posedge clk) begin
        r_req_q <= sched.req;
    end

    // State, arbitration, frame sequencing and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_pending     <= 4'b0000;
            r_rr_ptr      <= 2'd0;
            r_grant       <= 2'd0;
            r_byte_idx    <= '0;
            r_timer       <= '0;
            r_tx_data     <= 8'h00;
            r_drop_cnt    <= 8'h00;
            r_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_clear) | w_rise;
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (r_state == c_GRANT) begin
                r_grant    <= w_rr_grant;
                r_rr_ptr   <= w_rr_grant + 2'd1;
                r_byte_idx <= '0;
            end else if (w_adv) begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (w_load) begin
                r_tx_data <= w_data_nxt;
            end
            // Timer restarts when a byte is loaded and when it is launched.
            if (w_load || w_tx_start) begin
                r_timer <= '0;
            end else if (r_state == c_LOAD || r_state == c_WAIT) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign sched.tx_start    = w_tx_start;
    assign sched.tx_data     = r_tx_data;
    assign sched.busy        = (r_state != c_IDLE);
    assign sched.grant_id    = (r_state == c_GRANT) ? w_rr_grant : r_grant;
    assign sched.pending     = r_pending;
    assign sched.drop_cnt    = r_drop_cnt;
    assign sched.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Randomized and directed bench for uart_tx_scheduler with a
//                frame-level reference model, a transmitter model and a
//                scoreboard monitor on tx_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int unsigned TIMEOUT = 100;
`ifdef UART_TX_CRLF_EN
    localparam int FRAME_LEN = 3;
`else
    localparam int FRAME_LEN = 1;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if sif ();

    uart_tx_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .sched (sif.slave)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   model_rr = 0;
    int   exp_drop = 0;
    int   tx_len   = 10;
    bit   hang     = 1'b0;
    bit   train_mode = 1'b0;
    int   train_frames = 0;
    int   train_k = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req_v);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    function automatic logic [7:0] frame_byte(input int id, input int k);
        if (k == 1) return 8'h0D;
        if (k == 2) return 8'h0A;
        case (id)
            0:       return 8'h53;
            1:       return 8'h42;
            2:       return 8'h4F;
            default: return 8'h52;
        endcase
    endfunction

    function automatic void push_frame(input int id, input int nbytes);
        exp_t e;
        for (int k = 0; k < nbytes; k++) begin
            e.id   = 2'(id);
            e.data = frame_byte(id, k);
            exp_q.push_back(e);
        end
        model_rr = (id + 1) % 4;
    endfunction

    // All bits of mask are pending together: serve them in rotating order.
    function automatic void model_burst(input logic [3:0] mask);
        int start;
        int id;
        start = model_rr;
        for (int k = 0; k < 4; k++) begin
            id = (start + k) % 4;
            if (mask[id]) push_frame(id, FRAME_LEN);
        end
    endfunction

    // ---------------- transmitter model ----------------
    initial begin
        logic st;
        logic rs;
        int   tx_cnt;
        tx_cnt = 0;
        sif.tx_busy = 1'b0;
        sif.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            st = sif.tx_start;
            rs = reset;
            #1;
            sif.tx_done = 1'b0;
            if (rs) begin
                sif.tx_busy = 1'b0;
                tx_cnt = 0;
            end else if (st === 1'b1) begin
                sif.tx_busy = 1'b1;
                tx_cnt = tx_len;
            end else if (tx_cnt > 0) begin
                tx_cnt--;
            end else if (sif.tx_busy && !hang) begin
                sif.tx_done = 1'b1;
                sif.tx_busy = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : p_mon
        exp_t e;
        if (!reset && sif.tx_start === 1'b1) begin
            check("start_while_tx_busy", sif.tx_busy, 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tx_data", sif.tx_data, e.data);
                check("grant_id", sif.grant_id, e.id);
            end else if (train_mode) begin
                if (train_k == 0) train_frames++;
                check("train_grant_id", sif.grant_id, 2);
                check("train_tx_data", sif.tx_data, frame_byte(2, train_k));
                train_k = (train_k + 1) % FRAME_LEN;
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tx_start: got data %0h id %0d, required no start",
                         sif.tx_data, sif.grant_id);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        sif.req = m;
        tick();
        sif.req = 4'b0000;
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sif.tx_start === 1'b1) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no tx_start in 500 cycles, required one", name);
    endtask

    task automatic wait_dones(input int n, input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 1000 && seen < n; i++) begin
            @(negedge clk);
            if (sif.tx_done === 1'b1) seen++;
        end
        if (seen < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got %0d tx_done, required %0d", name, seen, n);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sif.busy === 1'b0 && sif.pending === 4'b0000 &&
                sif.tx_busy === 1'b0 && exp_q.size() == 0) begin
                tick();
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: got busy=%0b pending=%0h queued=%0d, required idle",
                 name, sif.busy, sif.pending, exp_q.size());
        exp_q.delete();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        model_rr = 0;
        exp_drop = 0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_tx_start"}, sif.tx_start, 0);
        check({tag, "_tx_data"}, sif.tx_data, 0);
        check({tag, "_busy"}, sif.busy, 0);
        check({tag, "_grant_id"}, sif.grant_id, 0);
        check({tag, "_pending"}, sif.pending, 0);
        check({tag, "_drop_cnt"}, sif.drop_cnt, 0);
        check({tag, "_timeout_err"}, sif.timeout_err, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        int dt;
        int exp_sat;
        logic [3:0] mask;
        sif.req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        // req during the reset cycle must be ignored
        sif.req = 4'b0100;
        tick();
        reset = 1'b0;
        sif.req = 4'b0000;
        @(negedge clk);
        check_zero_outputs("reset");
        tick();
        check("reset_req_ignored", sif.pending, 0);

        // 1: single request, latency and byte content
        tx_len = 10;
        model_burst(4'b0001);
        pulse(4'b0001);
        @(negedge clk);
        check("busy_in_grant", sif.busy, 1);
        check("no_start_in_grant", sif.tx_start, 0);
        @(negedge clk);
        check("latency_tx_start", sif.tx_start, 1);
        check("latency_tx_data", sif.tx_data, 8'h53);
        wait_dones(FRAME_LEN, "t1_dones");
        @(negedge clk);
        check("busy_after_frame", sif.busy, 0);
        tick();
        wait_idle("t1_idle");

        // 2: all four at once, then wrapped pointer
        do_reset();
        model_burst(4'b1111);
        pulse(4'b1111);
        wait_idle("t2a_idle");
        check("t2_drop_cnt", sif.drop_cnt, 0);
        model_burst(4'b0011);
        pulse(4'b0011);
        wait_idle("t2b_idle");

        // 3a: duplicate before grant counts one drop, one frame
        tx_len = 10;
        model_burst(4'b0010);
        pulse(4'b0010);
        wait_start("t3_start");
        tick();
        model_burst(4'b0100);
        pulse(4'b0100);
        tick();
        pulse(4'b0100);
        exp_drop = 1;
        @(negedge clk);
        check("t3_drop_one", sif.drop_cnt, exp_drop);
        wait_idle("t3a_idle");
        check("t3_drop_after_frame", sif.drop_cnt, exp_drop);

        // 3b: 300 more pulses; every pulse is either a frame or a drop
        tx_len = 40;
        train_frames = 0;
        train_k = 0;
        train_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            pulse(4'b0100);
            tick();
        end
        wait_idle("t3b_idle");
        train_mode = 1'b0;
        exp_sat = exp_drop + 300 - train_frames;
        exp_drop = (exp_sat > 255) ? 255 : exp_sat;
        check("t3_drop_saturated", sif.drop_cnt, exp_drop);
        check("t3_drop_is_255", sif.drop_cnt, 255);
        model_rr = 3;

        // 4: timeout, frame abandoned, next request held until tx_busy falls
        tx_len = 10;
        hang = 1'b1;
        push_frame(0, 1);
        pulse(4'b0001);
        wait_start("t4_start");
        t0 = cyc;
        tick();
        model_burst(4'b1000);
        pulse(4'b1000);
        dt = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sif.timeout_err === 1'b1) begin
                dt = cyc - t0;
                break;
            end
        end
        n_cmp++;
        if (dt < int'(TIMEOUT) || dt > int'(TIMEOUT) + 2) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d",
                     dt, TIMEOUT, TIMEOUT + 2);
        end
        repeat (20) @(negedge clk);
        check("t4_hold_busy", sif.busy, 1);
        check("t4_hold_grant", sif.grant_id, 3);
        hang = 1'b0;
        wait_idle("t4_idle");
        check("t4_timeout_sticky", sif.timeout_err, 1);

        // 5: new req[0] in the cycle its pending bit is cleared by grant
        tx_len = 10;
        model_burst(4'b0010);
        pulse(4'b0010);
        wait_start("t5_start");
        tick();
        model_burst(4'b0001);
        pulse(4'b0001);
        wait_dones(FRAME_LEN, "t5_dones");
        @(posedge clk);
        @(posedge clk);
        #1;
        push_frame(0, FRAME_LEN);
        pulse(4'b0001);
        @(negedge clk);
        check("t5_pending0_kept", sif.pending[0], 1);
        check("t5_drop_unchanged", sif.drop_cnt, exp_drop);
        wait_idle("t5_idle");
        check("t5_drop_final", sif.drop_cnt, exp_drop);

        // random bursts issued while idle
        for (int it = 0; it < 25; it++) begin
            tx_len = $urandom_range(2, 15);
            mask = 4'($urandom_range(1, 15));
            repeat ($urandom_range(0, 3)) tick();
            model_burst(mask);
            pulse(mask);
            wait_idle("rand_idle");
        end
        check("rand_drop_unchanged", sif.drop_cnt, exp_drop);

        // 6: reset mid-frame
        tx_len = 10;
        model_burst(4'b0100);
        pulse(4'b0100);
        wait_start("t6_start");
        tick();
        pulse(4'b0010);
        do_reset();
        @(negedge clk);
        check_zero_outputs("midreset");
        repeat (40) @(negedge clk);
        check("t6_quiet_busy", sif.busy, 0);
        tick();
        model_burst(4'b0001);
        pulse(4'b0001);
        wait_idle("t6_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
